// File: rtl/sii_dmu_inb_rcv_pkg.sv
// sii_inb_pkg: shared types for the DMU->SII inbound receiver
//   inb_typ_e  : descriptor type (RD/WR/MONDO/PIORET)
//   inb_st_e   : receive FSM state
//   inb_desc_t : queued descriptor {hdr, typ, slot}
//   par_ok()   : even parity check, one bit per 16-bit lane
package sii_inb_pkg;

    typedef enum logic [1:0] {
        TYP_RD     = 2'd0,
        TYP_WR     = 2'd1,
        TYP_MONDO  = 2'd2,
        TYP_PIORET = 2'd3
    } inb_typ_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WPAY,
        ST_MPAY
    } inb_st_e;

    typedef struct packed {
        logic [127:0] hdr;
        inb_typ_e     typ;
        logic [3:0]   slot;
    } inb_desc_t;

    localparam int BEATS     = 4;
    localparam int ERR_PAR   = 0;
    localparam int ERR_OVF   = 1;
    localparam int ERR_PROTO = 2;

    function automatic logic par_ok(input logic [127:0] d, input logic [7:0] p);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++)
            ok = ok & ((^d[16*i +: 16]) == p[i]);
        return ok;
    endfunction

endpackage

// File: rtl/sii_dmu_inb_rcv_if.sv
// sii_dmu_inb_if: DMU->SII inbound bus
//   dmu modport : drives header/payload, receives write-ack credits
//   sii modport : receives header/payload, returns write-ack credits
interface sii_dmu_inb_if;
    logic         dmu_sii_hdr_vld;
    logic         dmu_sii_reqbypass;
    logic         dmu_sii_datareq;
    logic         dmu_sii_datareq16;
    logic [127:0] dmu_sii_data;
    logic [7:0]   dmu_sii_parity;
    logic [15:0]  dmu_sii_be;
    logic         sii_dmu_wrack_vld;
    logic [3:0]   sii_dmu_wrack_tag;

    modport dmu (
        output dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16,
               dmu_sii_data, dmu_sii_parity, dmu_sii_be,
        input  sii_dmu_wrack_vld, sii_dmu_wrack_tag
    );

    modport sii (
        input  dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16,
               dmu_sii_data, dmu_sii_parity, dmu_sii_be,
        output sii_dmu_wrack_vld, sii_dmu_wrack_tag
    );
endinterface

// File: rtl/sii_dmu_inb_rcv_fifo.sv
// sii_inb_fifo: DEPTH-entry descriptor FIFO
//   push/din : enqueue; dropped with ovf=1 when full and no pop this cycle
//   pop      : dequeue head when vld
//   dout/vld : head descriptor and non-empty flag
module sii_inb_fifo
    import sii_inb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      iol2clk,
    input  logic      rst_l,
    input  logic      push,
    input  logic      pop,
    input  inb_desc_t din,
    output inb_desc_t dout,
    output logic      vld,
    output logic      ovf
);
    localparam int AW = $clog2(DEPTH);

    inb_desc_t       mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     cnt;
    logic            full, do_push, do_pop;

    assign vld     = cnt != '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_pop  = pop & vld;
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push & (~full | do_pop);
    assign ovf     = push & full & ~do_pop;
    assign dout    = mem[rp];

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push)
                mem[wp] <= din;
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sii_dmu_inb_rcv.sv
// sii_dmu_inb_rcv: SIU receiver for inbound DMU->SII traffic
//   dmu            : inbound bus (header/payload in, wrack credits out)
//   oq_* / bq_*    : ordered / bypass descriptor queue heads, popped on vld&rdy
//   pld_wr_*       : payload buffer write port, addr = {slot, beat}
//   sii_inb_err    : sticky {proto, overflow, parity}
//   SII_INB_PARCHK_EN : when defined, parity is checked on header and payload beats
module sii_dmu_inb_rcv
    import sii_inb_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int PLD_SLOTS = 16
) (
    input  logic          iol2clk,
    input  logic          rst_l,
    sii_dmu_inb_if.sii    dmu,
    output logic          oq_vld,
    input  logic          oq_rdy,
    output logic [127:0]  oq_hdr,
    output logic [1:0]    oq_typ,
    output logic [3:0]    oq_slot,
    output logic          bq_vld,
    input  logic          bq_rdy,
    output logic [127:0]  bq_hdr,
    output logic [1:0]    bq_typ,
    output logic [3:0]    bq_slot,
    output logic          pld_wr_en,
    output logic [5:0]    pld_wr_addr,
    output logic [127:0]  pld_wr_data,
    output logic [15:0]   pld_wr_be,
    output logic [2:0]    sii_inb_err
);
    inb_st_e      st, st_nx;
    logic [1:0]   beat, beat_nx;
    logic [127:0] cur_hdr;
    inb_typ_e     cur_typ, new_typ;
    logic         cur_byp;
    logic [3:0]   cur_slot, slot_cnt;
    logic         hdr_take, push, push_byp, proto, par_bad;
    inb_desc_t    desc, oq_d, bq_d;
    logic         oq_ovf, bq_ovf, bq_fvld;
    logic         oq_wr, bq_wr, hold_vld, wrack_vld;
    logic [3:0]   hold_tag, wrack_tag;

    assign new_typ = dmu.dmu_sii_datareq16 ? (dmu.dmu_sii_reqbypass ? TYP_PIORET : TYP_MONDO) : TYP_WR;

    always_comb begin
        st_nx       = st;
        beat_nx     = beat;
        hdr_take    = 1'b0;
        push        = 1'b0;
        push_byp    = cur_byp;
        proto       = 1'b0;
        desc        = '{hdr: cur_hdr, typ: cur_typ, slot: cur_slot};
        pld_wr_en   = 1'b0;
        pld_wr_addr = '0;
        pld_wr_data = '0;
        pld_wr_be   = '0;
        case (st)
            ST_IDLE: begin
                if (dmu.dmu_sii_hdr_vld) begin
                    if (!dmu.dmu_sii_datareq && dmu.dmu_sii_datareq16) begin
                        proto = 1'b1;
                    end else if (!dmu.dmu_sii_datareq) begin
                        push     = 1'b1;
                        push_byp = dmu.dmu_sii_reqbypass;
                        desc     = '{hdr: dmu.dmu_sii_data, typ: TYP_RD, slot: 4'd0};
                    end else begin
                        hdr_take = 1'b1;
                        beat_nx  = '0;
                        st_nx    = dmu.dmu_sii_datareq16 ? ST_MPAY : ST_WPAY;
                    end
                end
            end
            ST_WPAY: begin
                proto       = dmu.dmu_sii_hdr_vld;
                pld_wr_en   = 1'b1;
                pld_wr_addr = {cur_slot, beat};
                pld_wr_data = dmu.dmu_sii_data;
                pld_wr_be   = dmu.dmu_sii_be;
                beat_nx     = beat + 2'd1;
                if (beat == 2'(BEATS-1)) begin
                    push  = 1'b1;
                    st_nx = ST_IDLE;
                end
            end
            ST_MPAY: begin
                proto       = dmu.dmu_sii_hdr_vld;
                pld_wr_en   = 1'b1;
                pld_wr_addr = {cur_slot, 2'b00};
                pld_wr_data = dmu.dmu_sii_data;
                pld_wr_be   = '1;
                push        = 1'b1;
                st_nx       = ST_IDLE;
            end
            default: st_nx = ST_IDLE;
        endcase
    end

`ifdef SII_INB_PARCHK_EN
    // in IDLE only a real header cycle carries meaningful parity
    assign par_bad = ((st == ST_IDLE) ? dmu.dmu_sii_hdr_vld : 1'b1) &
                     ~par_ok(dmu.dmu_sii_data, dmu.dmu_sii_parity);
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            st          <= ST_IDLE;
            beat        <= '0;
            cur_hdr     <= '0;
            cur_typ     <= TYP_RD;
            cur_byp     <= 1'b0;
            cur_slot    <= '0;
            slot_cnt    <= '0;
            sii_inb_err <= '0;
        end else begin
            st   <= st_nx;
            beat <= beat_nx;
            if (hdr_take) begin
                cur_hdr  <= dmu.dmu_sii_data;
                cur_typ  <= new_typ;
                cur_byp  <= dmu.dmu_sii_reqbypass;
                cur_slot <= slot_cnt;
                slot_cnt <= (slot_cnt == 4'(PLD_SLOTS-1)) ? 4'd0 : slot_cnt + 4'd1;
            end
            sii_inb_err[ERR_PROTO] <= sii_inb_err[ERR_PROTO] | proto;
            sii_inb_err[ERR_OVF]   <= sii_inb_err[ERR_OVF] | oq_ovf | bq_ovf;
            sii_inb_err[ERR_PAR]   <= sii_inb_err[ERR_PAR] | par_bad;
        end
    end

    sii_inb_fifo #(.DEPTH(QDEPTH)) u_oq (
        .iol2clk (iol2clk),
        .rst_l   (rst_l),
        .push    (push & ~push_byp),
        .pop     (oq_rdy),
        .din     (desc),
        .dout    (oq_d),
        .vld     (oq_vld),
        .ovf     (oq_ovf)
    );

    sii_inb_fifo #(.DEPTH(QDEPTH)) u_bq (
        .iol2clk (iol2clk),
        .rst_l   (rst_l),
        .push    (push & push_byp),
        .pop     (bq_vld & bq_rdy),
        .din     (desc),
        .dout    (bq_d),
        .vld     (bq_fvld),
        .ovf     (bq_ovf)
    );

    assign oq_hdr  = oq_d.hdr;
    assign oq_typ  = oq_d.typ;
    assign oq_slot = oq_d.slot;
    assign bq_hdr  = bq_d.hdr;
    assign bq_typ  = bq_d.typ;
    assign bq_slot = bq_d.slot;

    // BQ head is hidden while an ack is held so the holding register never needs a second entry
    assign bq_vld = bq_fvld & ~hold_vld;
    assign oq_wr  = oq_vld & oq_rdy & (oq_typ == TYP_WR);
    assign bq_wr  = bq_vld & bq_rdy & (bq_typ == TYP_WR);

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            wrack_vld <= 1'b0;
            wrack_tag <= '0;
            hold_vld  <= 1'b0;
            hold_tag  <= '0;
        end else if (hold_vld) begin
            wrack_vld <= 1'b1;
            wrack_tag <= hold_tag;
            hold_vld  <= oq_wr;
            hold_tag  <= oq_slot;
        end else if (oq_wr) begin
            wrack_vld <= 1'b1;
            wrack_tag <= oq_slot;
            hold_vld  <= bq_wr;
            hold_tag  <= bq_slot;
        end else begin
            wrack_vld <= bq_wr;
            wrack_tag <= bq_slot;
        end
    end

    assign dmu.sii_dmu_wrack_vld = wrack_vld;
    assign dmu.sii_dmu_wrack_tag = wrack_tag;
endmodule

// File: tb/tb_sii_dmu_inb_rcv.sv
// tb_sii_dmu_inb_rcv: directed self-checking bench for sii_dmu_inb_rcv
module tb_sii_dmu_inb_rcv;
    logic         iol2clk = 1'b0;
    logic         rst_l   = 1'b0;
    logic         oq_vld, oq_rdy, bq_vld, bq_rdy;
    logic [127:0] oq_hdr, bq_hdr, pld_wr_data;
    logic [1:0]   oq_typ, bq_typ;
    logic [3:0]   oq_slot, bq_slot;
    logic         pld_wr_en;
    logic [5:0]   pld_wr_addr;
    logic [15:0]  pld_wr_be;
    logic [2:0]   sii_inb_err;
    int           tests = 0;
    int           fails = 0;

`ifdef SII_INB_PARCHK_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    always #5 iol2clk = ~iol2clk;

    sii_dmu_inb_if bus();

    sii_dmu_inb_rcv dut (
        .iol2clk     (iol2clk),
        .rst_l       (rst_l),
        .dmu         (bus),
        .oq_vld      (oq_vld),
        .oq_rdy      (oq_rdy),
        .oq_hdr      (oq_hdr),
        .oq_typ      (oq_typ),
        .oq_slot     (oq_slot),
        .bq_vld      (bq_vld),
        .bq_rdy      (bq_rdy),
        .bq_hdr      (bq_hdr),
        .bq_typ      (bq_typ),
        .bq_slot     (bq_slot),
        .pld_wr_en   (pld_wr_en),
        .pld_wr_addr (pld_wr_addr),
        .pld_wr_data (pld_wr_data),
        .pld_wr_be   (pld_wr_be),
        .sii_inb_err (sii_inb_err)
    );

    function automatic logic [7:0] gpar(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++)
            p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    task automatic tick;
        @(posedge iol2clk);
        #1;
    endtask

    task automatic drv(input logic hv, input logic byp, input logic dr, input logic dr16,
                       input logic [127:0] d, input logic [15:0] be);
        bus.dmu_sii_hdr_vld   = hv;
        bus.dmu_sii_reqbypass = byp;
        bus.dmu_sii_datareq   = dr;
        bus.dmu_sii_datareq16 = dr16;
        bus.dmu_sii_data      = d;
        bus.dmu_sii_parity    = gpar(d);
        bus.dmu_sii_be        = be;
    endtask

    task automatic idle;
        drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset;
        idle();
        oq_rdy = 1'b0;
        bq_rdy = 1'b0;
        rst_l  = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
        tick();
    endtask

    task automatic send_wr(input logic byp, input logic [127:0] h);
        drv(1'b1, byp, 1'b1, 1'b0, h, '0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 128'(k + 1), 16'hFFFF);
            tick();
        end
        idle();
    endtask

    task automatic test_reset;
        idle();
        oq_rdy = 1'b0;
        bq_rdy = 1'b0;
        rst_l  = 1'b0;
        tick();
        tick();
        tests++; if (oq_vld !== 1'b0) begin fails++; $display("FAIL reset_oq_vld got=%b exp=0", oq_vld); end
        tests++; if (bq_vld !== 1'b0) begin fails++; $display("FAIL reset_bq_vld got=%b exp=0", bq_vld); end
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b0) begin fails++; $display("FAIL reset_wrack got=%b exp=0", bus.sii_dmu_wrack_vld); end
        tests++; if (sii_inb_err !== 3'b000) begin fails++; $display("FAIL reset_err got=%b exp=000", sii_inb_err); end
        tests++; if (pld_wr_en !== 1'b0) begin fails++; $display("FAIL reset_pld_en got=%b exp=0", pld_wr_en); end
        rst_l = 1'b1;
        tick();
    endtask

    task automatic test_rd;
        logic [127:0] h;
        do_reset();
        h = 128'h12_3456_7880;
        drv(1'b1, 1'b0, 1'b0, 1'b0, h, '0);
        #1;
        tests++; if (pld_wr_en !== 1'b0) begin fails++; $display("FAIL rd_pld_en got=%b exp=0", pld_wr_en); end
        tick();
        idle();
        tests++; if (oq_vld !== 1'b1) begin fails++; $display("FAIL rd_oq_vld got=%b exp=1", oq_vld); end
        tests++; if (oq_typ !== 2'd0) begin fails++; $display("FAIL rd_typ got=%0d exp=0", oq_typ); end
        tests++; if (oq_hdr !== h) begin fails++; $display("FAIL rd_hdr got=%h exp=%h", oq_hdr, h); end
        tests++; if (bq_vld !== 1'b0) begin fails++; $display("FAIL rd_bq_vld got=%b exp=0", bq_vld); end
        oq_rdy = 1'b1;
        tick();
        oq_rdy = 1'b0;
        tests++; if (oq_vld !== 1'b0) begin fails++; $display("FAIL rd_popped got=%b exp=0", oq_vld); end
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b0) begin fails++; $display("FAIL rd_no_wrack got=%b exp=0", bus.sii_dmu_wrack_vld); end
    endtask

    task automatic test_wr_bq;
        logic [127:0] h;
        do_reset();
        h = 128'hFEED_0001;
        drv(1'b1, 1'b1, 1'b1, 1'b0, h, '0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 128'(10 + k), 16'hFFFF);
            #1;
            tests++; if (pld_wr_en !== 1'b1) begin fails++; $display("FAIL wr_pld_en beat=%0d got=%b exp=1", k, pld_wr_en); end
            tests++; if (pld_wr_addr !== 6'(k)) begin fails++; $display("FAIL wr_addr beat=%0d got=%h exp=%h", k, pld_wr_addr, k); end
            tests++; if (pld_wr_data !== 128'(10 + k)) begin fails++; $display("FAIL wr_data beat=%0d got=%h exp=%h", k, pld_wr_data, 10 + k); end
            tests++; if (pld_wr_be !== 16'hFFFF) begin fails++; $display("FAIL wr_be beat=%0d got=%h exp=ffff", k, pld_wr_be); end
            tests++; if (bq_vld !== 1'b0) begin fails++; $display("FAIL wr_bq_early beat=%0d got=%b exp=0", k, bq_vld); end
            tick();
        end
        idle();
        tests++; if (bq_vld !== 1'b1) begin fails++; $display("FAIL wr_bq_vld got=%b exp=1", bq_vld); end
        tests++; if (bq_typ !== 2'd1) begin fails++; $display("FAIL wr_bq_typ got=%0d exp=1", bq_typ); end
        tests++; if (bq_slot !== 4'd0) begin fails++; $display("FAIL wr_bq_slot got=%0d exp=0", bq_slot); end
        tests++; if (bq_hdr !== h) begin fails++; $display("FAIL wr_bq_hdr got=%h exp=%h", bq_hdr, h); end
        tests++; if (oq_vld !== 1'b0) begin fails++; $display("FAIL wr_oq_vld got=%b exp=0", oq_vld); end
        bq_rdy = 1'b1;
        #1;
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b0) begin fails++; $display("FAIL wr_wrack_early got=%b exp=0", bus.sii_dmu_wrack_vld); end
        tick();
        bq_rdy = 1'b0;
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b1) begin fails++; $display("FAIL wr_wrack_vld got=%b exp=1", bus.sii_dmu_wrack_vld); end
        tests++; if (bus.sii_dmu_wrack_tag !== 4'd0) begin fails++; $display("FAIL wr_wrack_tag got=%0d exp=0", bus.sii_dmu_wrack_tag); end
        tick();
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b0) begin fails++; $display("FAIL wr_wrack_pulse got=%b exp=0", bus.sii_dmu_wrack_vld); end
    endtask

    task automatic test_slot_wrap;
        do_reset();
        oq_rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drv(1'b1, 1'b0, 1'b1, 1'b1, 128'(i), '0);
            tick();
            drv(1'b0, 1'b0, 1'b0, 1'b0, 128'(100 + i), '0);
            #1;
            tests++; if (pld_wr_addr !== 6'((i % 16) * 4)) begin fails++; $display("FAIL wrap_addr txn=%0d got=%h exp=%h", i, pld_wr_addr, (i % 16) * 4); end
            tests++; if (pld_wr_be !== 16'hFFFF) begin fails++; $display("FAIL wrap_be txn=%0d got=%h exp=ffff", i, pld_wr_be); end
            tick();
        end
        idle();
        tests++; if (oq_typ !== 2'd2) begin fails++; $display("FAIL wrap_mondo_typ got=%0d exp=2", oq_typ); end
        tests++; if (oq_slot !== 4'd0) begin fails++; $display("FAIL wrap_slot got=%0d exp=0", oq_slot); end
        tick();
        oq_rdy = 1'b0;
        tests++; if (sii_inb_err !== 3'b000) begin fails++; $display("FAIL wrap_err got=%b exp=000", sii_inb_err); end
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b0) begin fails++; $display("FAIL wrap_wrack got=%b exp=0", bus.sii_dmu_wrack_vld); end
    endtask

    task automatic test_overflow;
        logic [127:0] exp_h [4];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b0, 1'b0, 1'b0, 128'(i), '0);
            tick();
        end
        idle();
        tests++; if (sii_inb_err !== 3'b010) begin fails++; $display("FAIL ovf_err got=%b exp=010", sii_inb_err); end
        drv(1'b1, 1'b0, 1'b0, 1'b0, 128'h99, '0);
        oq_rdy = 1'b1;
        tick();
        oq_rdy = 1'b0;
        idle();
        tests++; if (sii_inb_err !== 3'b010) begin fails++; $display("FAIL ovf_pushpop_err got=%b exp=010", sii_inb_err); end
        exp_h = '{128'd1, 128'd2, 128'd3, 128'h99};
        for (int k = 0; k < 4; k++) begin
            tests++; if (oq_vld !== 1'b1 || oq_hdr !== exp_h[k]) begin fails++; $display("FAIL ovf_order idx=%0d got=%b/%h exp=1/%h", k, oq_vld, oq_hdr, exp_h[k]); end
            oq_rdy = 1'b1;
            tick();
            oq_rdy = 1'b0;
        end
        tests++; if (oq_vld !== 1'b0) begin fails++; $display("FAIL ovf_drained got=%b exp=0", oq_vld); end
    endtask

    task automatic test_parity;
        do_reset();
        drv(1'b1, 1'b0, 1'b1, 1'b0, 128'hABCD, '0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 128'h30 + 128'(k), 16'h00FF);
            if (k == 2)
                bus.dmu_sii_data = bus.dmu_sii_data ^ 128'h8;
            tick();
        end
        idle();
        tests++; if (sii_inb_err[0] !== PAR_EXP) begin fails++; $display("FAIL par_err got=%b exp=%b", sii_inb_err[0], PAR_EXP); end
        tests++; if (sii_inb_err[2:1] !== 2'b00) begin fails++; $display("FAIL par_other_err got=%b exp=00", sii_inb_err[2:1]); end
        tests++; if (oq_vld !== 1'b1 || oq_typ !== 2'd1) begin fails++; $display("FAIL par_queued got=%b/%0d exp=1/1", oq_vld, oq_typ); end
    endtask

    task automatic test_proto;
        do_reset();
        drv(1'b1, 1'b0, 1'b1, 1'b0, 128'h5A5A, '0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drv(k == 1, 1'b0, 1'b0, 1'b0, 128'h60 + 128'(k), 16'hFFFF);
            tick();
        end
        idle();
        tests++; if (sii_inb_err !== 3'b100) begin fails++; $display("FAIL proto_mid_err got=%b exp=100", sii_inb_err); end
        tests++; if (oq_vld !== 1'b1 || oq_typ !== 2'd1 || oq_hdr !== 128'h5A5A) begin fails++; $display("FAIL proto_mid_desc got=%b/%0d/%h exp=1/1/5a5a", oq_vld, oq_typ, oq_hdr); end
        oq_rdy = 1'b1;
        tick();
        oq_rdy = 1'b0;
        tests++; if (oq_vld !== 1'b0) begin fails++; $display("FAIL proto_mid_extra got=%b exp=0", oq_vld); end
        do_reset();
        drv(1'b1, 1'b0, 1'b0, 1'b1, 128'h77, '0);
        tick();
        idle();
        #1;
        tests++; if (sii_inb_err !== 3'b100) begin fails++; $display("FAIL proto_01_err got=%b exp=100", sii_inb_err); end
        tests++; if (oq_vld !== 1'b0 || bq_vld !== 1'b0) begin fails++; $display("FAIL proto_01_q got=%b/%b exp=0/0", oq_vld, bq_vld); end
        tests++; if (pld_wr_en !== 1'b0) begin fails++; $display("FAIL proto_01_pld got=%b exp=0", pld_wr_en); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        drv(1'b1, 1'b0, 1'b1, 1'b0, 128'h4242, '0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 128'(k), 16'hFFFF);
            tick();
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 128'd2, 16'hFFFF);
        #1;
        rst_l = 1'b0;
        #1;
        tests++; if (pld_wr_en !== 1'b0) begin fails++; $display("FAIL rstmid_pld got=%b exp=0", pld_wr_en); end
        tick();
        idle();
        tick();
        rst_l = 1'b1;
        oq_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            tests++; if (oq_vld !== 1'b0 || bus.sii_dmu_wrack_vld !== 1'b0) begin fails++; $display("FAIL rstmid_quiet cyc=%0d got=%b/%b exp=0/0", c, oq_vld, bus.sii_dmu_wrack_vld); end
        end
        oq_rdy = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        send_wr(1'b0, 128'h1111);
        send_wr(1'b1, 128'h2222);
        tests++; if (oq_slot !== 4'd0 || bq_slot !== 4'd1) begin fails++; $display("FAIL b2b_slots got=%0d/%0d exp=0/1", oq_slot, bq_slot); end
        oq_rdy = 1'b1;
        bq_rdy = 1'b1;
        tick();
        oq_rdy = 1'b0;
        bq_rdy = 1'b0;
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b1 || bus.sii_dmu_wrack_tag !== 4'd0) begin fails++; $display("FAIL b2b_ack1 got=%b/%0d exp=1/0", bus.sii_dmu_wrack_vld, bus.sii_dmu_wrack_tag); end
        tick();
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b1 || bus.sii_dmu_wrack_tag !== 4'd1) begin fails++; $display("FAIL b2b_ack2 got=%b/%0d exp=1/1", bus.sii_dmu_wrack_vld, bus.sii_dmu_wrack_tag); end
        tick();
        tests++; if (bus.sii_dmu_wrack_vld !== 1'b0) begin fails++; $display("FAIL b2b_ack_end got=%b exp=0", bus.sii_dmu_wrack_vld); end
        tests++; if (oq_vld !== 1'b0 || bq_vld !== 1'b0) begin fails++; $display("FAIL b2b_empty got=%b/%b exp=0/0", oq_vld, bq_vld); end
    endtask

    initial begin
        test_reset();
        test_rd();
        test_wr_bq();
        test_slot_wrap();
        test_overflow();
        test_parity();
        test_proto();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
